// File: rtl/aplic_msi_write_arbiter.sv
// aplic_msi_write_arbiter
// Round-robin arbiter that shares a single simplified AXI4 write master
// between NrReq MSI requesters. One write is in flight at a time; the
// served requester receives a one-cycle completion pulse with an error flag.
module aplic_msi_write_arbiter #(
    parameter int NrReq = 2,
    parameter int AddrW = 64,
    parameter int EiidW = 11
) (
    input  logic                   i_clk,
    input  logic                   ni_rst,
    input  logic [NrReq-1:0]       i_req_valid,
    output logic [NrReq-1:0]       o_req_ready,
    input  logic [NrReq*AddrW-1:0] i_req_addr,
    input  logic [NrReq*EiidW-1:0] i_req_eiid,
    output logic [NrReq-1:0]       o_done_valid,
    output logic                   o_done_err,
    output logic                   o_aw_valid,
    input  logic                   i_aw_ready,
    output logic [AddrW-1:0]       o_aw_addr,
    output logic                   o_w_valid,
    input  logic                   i_w_ready,
    output logic [31:0]            o_w_data,
    output logic [3:0]             o_w_strb,
    input  logic                   i_b_valid,
    output logic                   o_b_ready,
    input  logic [1:0]             i_b_resp,
    output logic                   o_busy
);

    localparam int PtrW = (NrReq > 1) ? $clog2(NrReq) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        WAIT_B = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [PtrW-1:0]   gnt_q, gnt_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic [EiidW-1:0]  eiid_q, eiid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              err_q, err_d;

    logic              arb_found;
    logic [PtrW-1:0]   arb_idx;
    logic [AddrW-1:0]  arb_addr;
    logic [EiidW-1:0]  arb_eiid;
    int                arb_dist;
    int                arb_best;

    // Round-robin pick: the valid requester at the smallest distance above the pointer wins
    always_comb begin
        arb_idx  = '0;
        arb_addr = '0;
        arb_eiid = '0;
        arb_dist = 0;
        arb_best = NrReq;
        for (int k = 0; k < NrReq; k++) begin
            arb_dist = k - int'(ptr_q);
            if (arb_dist < 0) begin
                arb_dist = arb_dist + NrReq;
            end
            if (i_req_valid[k] && (arb_dist < arb_best)) begin
                arb_best = arb_dist;
                arb_idx  = PtrW'(k);
                arb_addr = i_req_addr[k*AddrW +: AddrW];
                arb_eiid = i_req_eiid[k*EiidW +: EiidW];
            end
        end
        arb_found = (arb_best < NrReq);
    end

    // Transaction sequencing: accept in IDLE, run AW/W then B, then pulse completion
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        eiid_d    = eiid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    gnt_d     = arb_idx;
                    addr_d    = arb_addr;
                    eiid_d    = arb_eiid;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = 1'b0;
                    if (int'(arb_idx) == NrReq - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = arb_idx + PtrW'(1);
                    end
                    // EIID 0 is not a valid identity, so the write is dropped
                    state_d = (arb_eiid != '0) ? SEND : RESP;
                end
            end
            SEND: begin
                aw_done_d = aw_done_q | i_aw_ready;
                w_done_d  = w_done_q | i_w_ready;
                if (aw_done_d && w_done_d) begin
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_b_valid) begin
                    err_d   = (i_b_resp != 2'b00);
                    state_d = RESP;
                end
            end
            RESP: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and transaction registers; reset abandons any in-flight write
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            addr_q    <= '0;
            eiid_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            eiid_q    <= eiid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

    // Port drive decoded from registered state; ready is held low while reset is applied
    always_comb begin
        o_req_ready  = '0;
        o_done_valid = '0;
        for (int k = 0; k < NrReq; k++) begin
            o_req_ready[k]  = ni_rst && (state_q == IDLE) && arb_found && (int'(arb_idx) == k);
            o_done_valid[k] = (state_q == RESP) && (int'(gnt_q) == k);
        end
        o_done_err            = (state_q == RESP) && err_q;
        o_aw_valid            = (state_q == SEND) && !aw_done_q;
        o_w_valid             = (state_q == SEND) && !w_done_q;
        o_b_ready             = (state_q == WAIT_B);
        o_busy                = (state_q != IDLE);
        o_aw_addr             = addr_q;
        o_w_data              = '0;
        o_w_data[EiidW-1:0]   = eiid_q;
        o_w_strb              = 4'hF;
    end

endmodule
